sram_fifo_ctrl: RTL and testbench
=================================

# sram_fifo_ctrl

Initiator-side FIFO controller that drives an external 1R1W SRAM (one read port, one write port) and exposes valid/ready push and pop streams. It owns the write/read pointers and occupancy. It hides the SRAM's one-cycle read latency behind a 2-entry output buffer, sustaining one push and one pop per cycle. It sits between stream producers/consumers and a `sram_1r1w` instance, which is configured with `READ_DURING_WRITE="DONT_CARE"` because the controller never reads an address in the cycle it is written.

## Interface
- `DATA_WIDTH`, 32, payload width.
- `DEPTH`, 1024, number of SRAM entries; any value ≥ 2.
- `ADDR_WIDTH` (localparam), `$clog2(DEPTH)`.
- `CNT_WIDTH` (localparam), `$clog2(DEPTH+3)`.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous clear, highest priority.
- `push_valid` / `push_ready` / `push_data`  in / out / in  1 / 1 / DATA_WIDTH  write stream.
- `pop_valid` / `pop_ready` / `pop_data`  out / in / out  1 / 1 / DATA_WIDTH  read stream.
- `count`  out  CNT_WIDTH  total entries held (SRAM + read in flight + output buffer).
- `sram_write_en` / `sram_write_addr` / `sram_write_data`  out  1 / ADDR_WIDTH / DATA_WIDTH  to SRAM write port.
- `sram_read_en` / `sram_read_addr`  out  1 / ADDR_WIDTH  to SRAM read port.
- `sram_read_data`  in  DATA_WIDTH  SRAM read result, valid the cycle after `sram_read_en`.

## Operation
- **State:**
  - `wr_ptr`, `rd_ptr`: 0..DEPTH-1; each increments by 1 and wraps from DEPTH-1 to 0.
  - `sram_cnt`: 0..DEPTH.
  - `inflight`: 1 bit.
  - Output buffer `obuf`: 2 entries with occupancy `ocnt` 0..2; head is `pop_data`.
- **Push fire:** `push_valid && push_ready`.
  - `push_ready = (sram_cnt != DEPTH)`, from registered state only.
  - A pop in the same cycle does not free space for a push.
- **Write:**
  - `sram_write_en` = push fire (and not bypassed, see Configuration).
  - `sram_write_addr = wr_ptr`, `sram_write_data = push_data`, all combinational.
  - `wr_ptr++` and `sram_cnt++` on write.
- **Read issue:**
  - `sram_read_en = (sram_cnt != 0) && (ocnt + inflight - pop_fire < 2)`, with `sram_read_addr = rd_ptr`.
  - On issue: `rd_ptr++`, `sram_cnt--`, `inflight` set for the next cycle.
  - A same-cycle write to the same address never occurs: `sram_cnt` counts only entries written in earlier cycles.
- **Return:** when `inflight` is set, `sram_read_data` is appended to `obuf`. There is always room by construction.
- **Pop:**
  - `pop_valid = (ocnt != 0)`; pop fire = `pop_valid && pop_ready`.
  - `obuf` shifts and `ocnt--`.
  - Append and pop in the same cycle preserve order.
- **Count:** `count = sram_cnt + inflight + ocnt`; maximum DEPTH+2.
  - Updated by +1 on push fire, -1 on pop fire, unchanged when both fire.
- **Flush:**
  - Pointers, `sram_cnt`, `inflight` and `ocnt` go to 0 on the next edge.
  - A read in flight at flush is discarded.
  - A push or pop presented in the flush cycle has no effect.
  - SRAM contents are not cleared.

## Timing
- **Reset values:**
  - `push_ready` = 1 (DEPTH ≥ 1).
  - `pop_valid`, `count`, `sram_write_en` and `sram_read_en` = 0.
  - `pop_data` = 0.
- **Latency, push to `pop_valid`** (empty FIFO, no bypass):
  - cycle 0 write;
  - cycle 1 read issued;
  - cycle 2 data returns, `obuf` loaded;
  - `pop_valid` visible in cycle 3, i.e. 3 edges after the push fire.
- **Throughput:** steady-state 1 push + 1 pop per cycle, with no bubbles.
- **Back-pressure:** with `pop_ready` low, at most 2 entries leave the SRAM (one in `obuf`, one in flight). Then reads stop.
- **Reset mid-operation:** asynchronous reset returns all state to reset values immediately. An in-flight read is lost.

## Configuration
- `SRAM_FIFO_BYPASS_EN`:
  - **Defined:** when `sram_cnt == 0`, `inflight == 0` and `ocnt - pop_fire < 2`, push fire writes `push_data` directly into `obuf` and `sram_write_en` stays 0. `pop_valid` then rises 1 edge after the push.
  - **Not defined:** every push goes through the SRAM, with the 3-edge latency above.
  - Ordering is identical in both builds.

## Structure
- **Shared package `sram_fifo_pkg`:** holds the `obuf` occupancy typedef (`logic [1:0]`) and the constant `OBUF_DEPTH = 2`.
- **Sub-module `sram_fifo_obuf`:** the 2-entry output buffer (append, pop, bypass append, flush) is a natural sub-module.
- **SRAM placement:** the SRAM is instantiated by the parent, not inside this block.

## Test plan
- **Single entry:** after reset, push `0xA5A5A5A5` with `pop_ready` high.
  - Write to address 0.
  - Read address 0 one cycle later.
  - `pop_valid` with `0xA5A5A5A5` 3 edges after the push (1 edge with `SRAM_FIFO_BYPASS_EN`).
  - `count` goes 1 → 0.
- **Fill:** `DEPTH=4`, `pop_ready` low, push 0..7.
  - Pushes 0..5 accepted; `push_ready` drops with `count == 6`.
  - `sram_read_en` issues exactly twice.
  - Popping then yields 0..5 in order.
- **Wrap-around:** `DEPTH=4`, stream 10 words with both sides always ready.
  - Addresses wrap 3 → 0.
  - Output equals input order.
  - One pop per cycle after the initial latency.
- **Random back-pressure:** 1000 words with random `push_valid` and `pop_ready`.
  - Scoreboard matches.
  - `count` never exceeds DEPTH+2.
  - Reads never overflow `obuf`.
  - A same-address read and write never occur in one cycle.
- **Flush with read in flight:** assert `flush` in the cycle after `sram_read_en`.
  - Next cycle: `count == 0`, `pop_valid == 0`.
  - The returning data is not presented.
  - A subsequent push of `0x1` pops as `0x1`.
- **Async reset mid-stream:** drop `rst_n` between clock edges.
  - `pop_valid`, `sram_read_en`, `sram_write_en` and `count` go to 0 immediately.
  - `push_ready` goes to 1.

Source files
------------

// File: rtl/sram_fifo_pkg.sv
// Shared types and constants for the SRAM-backed FIFO controller.
package sram_fifo_pkg;
  localparam int OBUF_DEPTH = 2;
  typedef logic [1:0] ocnt_t;
endpackage

// File: rtl/sram_fifo_obuf.sv
// Two-entry output buffer: absorbs SRAM read returns (or bypassed pushes) and
// presents the oldest entry as the pop head.
module sram_fifo_obuf
  import sram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  app_valid_i,
  input  logic [DATA_WIDTH-1:0] app_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic [1:0]            ocnt_o
);

  ocnt_t                 ocnt_q, ocnt_d, cnt_after_pop;
  logic [DATA_WIDTH-1:0] ent0_q, ent0_d, ent1_q, ent1_d;

  // Pop shifts first, then the append lands in the first free slot, so a
  // simultaneous append and pop keeps arrival order.
  always_comb begin
    cnt_after_pop = ocnt_q - ocnt_t'(pop_i);
    ent0_d        = pop_i ? ent1_q : ent0_q;
    ent1_d        = ent1_q;
    ocnt_d        = cnt_after_pop;
    if (app_valid_i) begin
      if (cnt_after_pop == 2'd0) begin
        ent0_d = app_data_i;
      end else begin
        ent1_d = app_data_i;
      end
      ocnt_d = cnt_after_pop + 2'd1;
    end
    if (flush_i) begin
      ocnt_d = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ocnt_q <= 2'd0;
      ent0_q <= '0;
      ent1_q <= '0;
    end else begin
      ocnt_q <= ocnt_d;
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
    end
  end

  assign head_o = ent0_q;
  assign ocnt_o = ocnt_q;

endmodule

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller for an external 1R1W SRAM with a 2-entry read-latency buffer.
// Optional macro SRAM_FIFO_BYPASS_EN: pushes into an empty FIFO skip the SRAM.
module sram_fifo_ctrl
  import sram_fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 1024,
  localparam int ADDR_WIDTH = $clog2(DEPTH),
  localparam int CNT_WIDTH  = $clog2(DEPTH + 3)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  pop_valid,
  input  logic                  pop_ready,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  sram_write_en,
  output logic [ADDR_WIDTH-1:0] sram_write_addr,
  output logic [DATA_WIDTH-1:0] sram_write_data,
  output logic                  sram_read_en,
  output logic [ADDR_WIDTH-1:0] sram_read_addr,
  input  logic [DATA_WIDTH-1:0] sram_read_data
);

  localparam int                    SCNT_WIDTH = $clog2(DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [SCNT_WIDTH-1:0] FULL_CNT   = SCNT_WIDTH'(DEPTH);
  localparam logic [2:0]            OBUF_LIM   = 3'(OBUF_DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [SCNT_WIDTH-1:0] sram_cnt_q, sram_cnt_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            ocnt;
  logic [2:0]            obuf_load;
  logic                  push_fire, pop_fire, bypass, wr_en, rd_en;
  logic                  app_valid;
  logic [DATA_WIDTH-1:0] app_data;

  // Space is judged on SRAM occupancy alone; the buffer slots are extra slack.
  assign push_ready = (sram_cnt_q != FULL_CNT);
  assign pop_valid  = (ocnt != 2'd0);
  assign push_fire  = push_valid && push_ready && !flush && rst_n;
  assign pop_fire   = pop_valid && pop_ready;

  // Buffer slots committed next cycle if no new read is issued now.
  assign obuf_load = {1'b0, ocnt} + {2'b00, inflight_q} - {2'b00, pop_fire};

`ifdef SRAM_FIFO_BYPASS_EN
  assign bypass = push_fire && (sram_cnt_q == '0) && !inflight_q &&
                  (({1'b0, ocnt} - {2'b00, pop_fire}) < OBUF_LIM);
`else
  assign bypass = 1'b0;
`endif

  assign wr_en = push_fire && !bypass;
  assign rd_en = !flush && (sram_cnt_q != '0) && (obuf_load < OBUF_LIM);

  assign sram_write_en   = wr_en;
  assign sram_write_addr = wr_ptr_q;
  assign sram_write_data = push_data;
  assign sram_read_en    = rd_en;
  assign sram_read_addr  = rd_ptr_q;

  assign app_valid = inflight_q || bypass;
  assign app_data  = inflight_q ? sram_read_data : push_data;

  assign count = CNT_WIDTH'(sram_cnt_q) + CNT_WIDTH'(inflight_q) + CNT_WIDTH'(ocnt);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    sram_cnt_d = sram_cnt_q + SCNT_WIDTH'(wr_en) - SCNT_WIDTH'(rd_en);
    inflight_d = rd_en;
    if (wr_en) begin
      wr_ptr_d = (wr_ptr_q == LAST_ADDR) ? '0 : ADDR_WIDTH'(wr_ptr_q + 1'b1);
    end
    if (rd_en) begin
      rd_ptr_d = (rd_ptr_q == LAST_ADDR) ? '0 : ADDR_WIDTH'(rd_ptr_q + 1'b1);
    end
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      sram_cnt_d = '0;
      inflight_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      sram_cnt_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      sram_cnt_q <= sram_cnt_d;
      inflight_q <= inflight_d;
    end
  end

  sram_fifo_obuf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_obuf (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush),
    .app_valid_i(app_valid),
    .app_data_i (app_data),
    .pop_i      (pop_fire),
    .head_o     (pop_data),
    .ocnt_o     (ocnt)
  );

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Randomised and directed bench for sram_fifo_ctrl (DEPTH=4) with an SRAM model
// and a queue-based FIFO reference.
module tb_sram_fifo_ctrl;
  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam int AW = 2;
  localparam int CW = 3;
`ifdef SRAM_FIFO_BYPASS_EN
  localparam int LAT = 1;
  localparam bit BYP = 1'b1;
`else
  localparam int LAT = 3;
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n, flush, push_valid, push_ready, pop_valid, pop_ready;
  logic [DW-1:0] push_data, pop_data, sram_write_data, sram_read_data;
  logic [CW-1:0] count;
  logic          sram_write_en, sram_read_en;
  logic [AW-1:0] sram_write_addr, sram_read_addr;

  always #5 clk = ~clk;

  sram_fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
    .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data),
    .count(count),
    .sram_write_en(sram_write_en), .sram_write_addr(sram_write_addr),
    .sram_write_data(sram_write_data),
    .sram_read_en(sram_read_en), .sram_read_addr(sram_read_addr),
    .sram_read_data(sram_read_data)
  );

  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (sram_write_en) mem[sram_write_addr] <= sram_write_data;
    if (sram_read_en) sram_read_data <= mem[sram_read_addr];
  end

  int vectors = 0;
  int miscompares = 0;
  logic [DW-1:0] q[$];
  int n_wr = 0, n_rd = 0;

  logic          s_pf, s_of, s_pv, s_pr, s_we, s_re;
  logic [DW-1:0] s_pd, s_exp;
  logic [AW-1:0] s_wa, s_ra;
  logic [CW-1:0] s_cnt;
  int            s_qsize, s_outside;

  // One clock cycle: drive at the falling edge, sample 1ns later, advance model at the rising edge.
  task automatic step(input logic pv, input logic [DW-1:0] pd, input logic pr, input logic fl);
    @(negedge clk);
    push_valid = pv; push_data = pd; pop_ready = pr; flush = fl;
    #1;
    s_pv = pop_valid; s_pr = push_ready; s_pd = pop_data; s_cnt = count;
    s_pf = push_valid && push_ready; s_of = pop_valid && pop_ready;
    s_we = sram_write_en; s_wa = sram_write_addr; s_re = sram_read_en; s_ra = sram_read_addr;
    s_qsize = q.size(); s_outside = q.size() - (n_wr - n_rd);
    s_exp = (q.size() > 0) ? q[0] : '0;
    @(posedge clk);
    if (fl) begin
      q.delete(); n_wr = 0; n_rd = 0;
    end else begin
      if (s_of && q.size() > 0) void'(q.pop_front());
      if (s_pf) q.push_back(pd);
      if (s_we) n_wr++;
      if (s_re) n_rd++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 0; push_valid = 0; pop_ready = 0; push_data = '0;
    #12;
    vectors++; if (push_ready !== 1'b1) begin miscompares++; $display("FAIL reset_push_ready got %b expected 1", push_ready); end
    vectors++; if (pop_valid !== 1'b0) begin miscompares++; $display("FAIL reset_pop_valid got %b expected 0", pop_valid); end
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL reset_count got %0d expected 0", count); end
    vectors++; if (sram_write_en !== 1'b0) begin miscompares++; $display("FAIL reset_we got %b expected 0", sram_write_en); end
    vectors++; if (sram_read_en !== 1'b0) begin miscompares++; $display("FAIL reset_re got %b expected 0", sram_read_en); end
    vectors++; if (pop_data !== '0) begin miscompares++; $display("FAIL reset_pop_data got %h expected 0", pop_data); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_single();
    int edges, lat, rd_at;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] got_data;
    step(0, '0, 1, 1);
    step(1, 32'hA5A5A5A5, 1, 0);
    vectors++; if (s_we !== !BYP) begin miscompares++; $display("FAIL single_we got %b expected %b", s_we, !BYP); end
    if (s_we) begin
      vectors++; if (s_wa !== 2'd0) begin miscompares++; $display("FAIL single_waddr got %0d expected 0", s_wa); end
    end
    edges = 1; lat = -1; rd_at = -1; rd_addr = '0; got_data = '0;
    for (int i = 0; i < 10 && lat < 0; i++) begin
      step(0, '0, 1, 0);
      if (i == 0) begin
        vectors++; if (s_cnt !== 3'd1) begin miscompares++; $display("FAIL single_count1 got %0d expected 1", s_cnt); end
      end
      if (s_re && rd_at < 0) begin rd_at = edges; rd_addr = s_ra; end
      if (s_pv) begin lat = edges; got_data = s_pd; end
      else edges++;
    end
    vectors++; if (lat != LAT) begin miscompares++; $display("FAIL single_latency got %0d expected %0d", lat, LAT); end
    vectors++; if (got_data !== 32'hA5A5A5A5) begin miscompares++; $display("FAIL single_data got %h expected a5a5a5a5", got_data); end
    vectors++; if (rd_at != (BYP ? -1 : 1)) begin miscompares++; $display("FAIL single_read_cycle got %0d expected %0d", rd_at, BYP ? -1 : 1); end
    if (rd_at >= 0) begin
      vectors++; if (rd_addr !== 2'd0) begin miscompares++; $display("FAIL single_raddr got %0d expected 0", rd_addr); end
    end
    step(0, '0, 1, 0);
    vectors++; if (s_cnt !== 3'd0) begin miscompares++; $display("FAIL single_count0 got %0d expected 0", s_cnt); end
    vectors++; if (s_pv !== 1'b0) begin miscompares++; $display("FAIL single_empty got %b expected 0", s_pv); end
  endtask

  task automatic test_fill();
    int idx, reads, k;
    step(0, '0, 0, 1);
    idx = 0; reads = 0;
    for (int c = 0; c < 20; c++) begin
      step(idx < 8, DW'(idx), 0, 0);
      if (s_re) reads++;
      if (s_pf) idx++;
    end
    vectors++; if (idx != 6) begin miscompares++; $display("FAIL fill_accepted got %0d expected 6", idx); end
    vectors++; if (s_pr !== 1'b0) begin miscompares++; $display("FAIL fill_push_ready got %b expected 0", s_pr); end
    vectors++; if (s_cnt !== 3'd6) begin miscompares++; $display("FAIL fill_count got %0d expected 6", s_cnt); end
    vectors++; if (reads != (BYP ? 0 : 2)) begin miscompares++; $display("FAIL fill_reads got %0d expected %0d", reads, BYP ? 0 : 2); end
    k = 0;
    for (int c = 0; c < 30 && k < 6; c++) begin
      step(0, '0, 1, 0);
      if (s_of) begin
        vectors++; if (s_pd !== DW'(k)) begin miscompares++; $display("FAIL fill_pop got %h expected %h", s_pd, DW'(k)); end
        k++;
      end
    end
    vectors++; if (k != 6) begin miscompares++; $display("FAIL fill_drain got %0d expected 6", k); end
  endtask

  task automatic test_wrap();
    int idx, npop, wcnt, bubbles;
    step(0, '0, 1, 1);
    idx = 0; npop = 0; wcnt = 0; bubbles = 0;
    for (int c = 0; c < 40 && npop < 10; c++) begin
      step(idx < 10, 32'd100 + DW'(idx), 1, 0);
      if (s_we) begin
        vectors++; if (s_wa !== AW'(wcnt % DEPTH)) begin miscompares++; $display("FAIL wrap_waddr got %0d expected %0d", s_wa, wcnt % DEPTH); end
        wcnt++;
      end
      if (s_pf) idx++;
      if (s_of) begin
        vectors++; if (s_pd !== 32'd100 + DW'(npop)) begin miscompares++; $display("FAIL wrap_data got %0d expected %0d", s_pd, 100 + npop); end
        npop++;
      end else if (npop > 0) bubbles++;
    end
    vectors++; if (npop != 10) begin miscompares++; $display("FAIL wrap_count got %0d expected 10", npop); end
    vectors++; if (bubbles != 0) begin miscompares++; $display("FAIL wrap_bubbles got %0d expected 0", bubbles); end
  endtask

  task automatic test_random();
    int sent, recv;
    logic pv, pr;
    step(0, '0, 0, 1);
    sent = 0; recv = 0;
    for (int c = 0; c < 8000 && recv < 1000; c++) begin
      pv = (sent < 1000) && ($urandom_range(0, 9) < 7);
      pr = ($urandom_range(0, 9) < 6);
      step(pv, $urandom, pr, 0);
      vectors++; if (int'(s_cnt) != s_qsize) begin miscompares++; $display("FAIL rand_count got %0d expected %0d", s_cnt, s_qsize); end
      vectors++; if (int'(s_cnt) > DEPTH + 2) begin miscompares++; $display("FAIL rand_count_max got %0d expected <= %0d", s_cnt, DEPTH + 2); end
      vectors++; if (s_outside > 2) begin miscompares++; $display("FAIL rand_obuf_overflow got %0d expected <= 2", s_outside); end
      vectors++; if (s_we && s_re && s_wa == s_ra) begin miscompares++; $display("FAIL rand_collision got addr %0d expected distinct", s_wa); end
      if (s_pf) sent++;
      if (s_of) begin
        vectors++; if (s_pd !== s_exp) begin miscompares++; $display("FAIL rand_data got %h expected %h", s_pd, s_exp); end
        recv++;
      end
    end
    vectors++; if (recv != 1000) begin miscompares++; $display("FAIL rand_received got %0d expected 1000", recv); end
  endtask

  task automatic test_flush_inflight();
    int got;
    step(0, '0, 0, 1);
    step(1, 32'hDEAD0001, 0, 0);
    step(0, '0, 0, 0);
    vectors++; if (s_re !== !BYP) begin miscompares++; $display("FAIL flush_read_issued got %b expected %b", s_re, !BYP); end
    step(0, '0, 1, 1);
    step(0, '0, 1, 0);
    vectors++; if (s_cnt !== 3'd0) begin miscompares++; $display("FAIL flush_count got %0d expected 0", s_cnt); end
    vectors++; if (s_pv !== 1'b0) begin miscompares++; $display("FAIL flush_pop_valid got %b expected 0", s_pv); end
    for (int i = 0; i < 3; i++) begin
      step(0, '0, 1, 0);
      vectors++; if (s_pv !== 1'b0) begin miscompares++; $display("FAIL flush_stale got %b expected 0", s_pv); end
    end
    step(1, 32'h1, 1, 0);
    got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      step(0, '0, 1, 0);
      if (s_of) begin
        got = 1;
        vectors++; if (s_pd !== 32'h1) begin miscompares++; $display("FAIL flush_repush got %h expected 1", s_pd); end
      end
    end
    vectors++; if (got != 1) begin miscompares++; $display("FAIL flush_repush_timeout got %0d expected 1", got); end
  endtask

  task automatic test_async_reset();
    int got;
    step(0, '0, 1, 1);
    for (int i = 0; i < 5; i++) step(1, 32'h200 + DW'(i), 1, 0);
    @(negedge clk);
    push_valid = 1; push_data = 32'h300; pop_ready = 1; flush = 0;
    #1;
    vectors++; if (int'(count) != q.size()) begin miscompares++; $display("FAIL areset_pre_count got %0d expected %0d", count, q.size()); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (pop_valid !== 1'b0) begin miscompares++; $display("FAIL areset_pop_valid got %b expected 0", pop_valid); end
    vectors++; if (sram_read_en !== 1'b0) begin miscompares++; $display("FAIL areset_re got %b expected 0", sram_read_en); end
    vectors++; if (sram_write_en !== 1'b0) begin miscompares++; $display("FAIL areset_we got %b expected 0", sram_write_en); end
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL areset_count got %0d expected 0", count); end
    vectors++; if (push_ready !== 1'b1) begin miscompares++; $display("FAIL areset_push_ready got %b expected 1", push_ready); end
    @(negedge clk);
    push_valid = 0; rst_n = 1'b1;
    q.delete(); n_wr = 0; n_rd = 0;
    step(1, 32'h77, 1, 0);
    got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      step(0, '0, 1, 0);
      if (s_of) begin
        got = 1;
        vectors++; if (s_pd !== 32'h77) begin miscompares++; $display("FAIL areset_after got %h expected 77", s_pd); end
      end
    end
    vectors++; if (got != 1) begin miscompares++; $display("FAIL areset_after_timeout got %0d expected 1", got); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_wrap();
    test_random();
    test_flush_inflight();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
